// File: rtl/alu_seq_control_if.sv
// ---------------------------------------------------------------------------
// alu_seq_control_if
//
// Purpose: bundles every signal exchanged between the hardwired control
// sequencer and the phase-1 single-bus datapath.
//
// Signals:
//   IR          32      datapath IR contents (opcode/Ra/Rb/Rc fields)
//   MemReady    1       memory read data valid on Mdatain
//   Stop        1       request to halt at the next instruction boundary
//   PCout, PCin, IncrementPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
//   ZLOout, ZHIout, HIin, LOin   1 each   datapath strobes
//   Rin, Rout   NREGS   one-hot register load / bus-drive selects
//   ALUControl  5       ALU op select
//   Run         1       high while sequencing, low in HALT
//   Illegal     1       one-cycle pulse on an undefined opcode
//
// Modports:
//   master  the sequencer (drives strobes, receives IR/MemReady/Stop)
//   slave   the datapath side
// ---------------------------------------------------------------------------
interface alu_seq_control_if #(
    parameter int NREGS = 16
);
    logic [31:0]      IR;
    logic             MemReady;
    logic             Stop;

    logic             PCout;
    logic             PCin;
    logic             IncrementPC;
    logic             MARin;
    logic             Read;
    logic             MDRin;
    logic             MDRout;
    logic             IRin;
    logic             Yin;
    logic             Zin;
    logic             ZLOout;
    logic             ZHIout;
    logic             HIin;
    logic             LOin;
    logic [NREGS-1:0] Rin;
    logic [NREGS-1:0] Rout;
    logic [4:0]       ALUControl;
    logic             Run;
    logic             Illegal;

    modport master (
        input  IR, MemReady, Stop,
        output PCout, PCin, IncrementPC, MARin, Read, MDRin, MDRout, IRin,
               Yin, Zin, ZLOout, ZHIout, HIin, LOin, Rin, Rout, ALUControl,
               Run, Illegal
    );

    modport slave (
        output IR, MemReady, Stop,
        input  PCout, PCin, IncrementPC, MARin, Read, MDRin, MDRout, IRin,
               Yin, Zin, ZLOout, ZHIout, HIin, LOin, Rin, Rout, ALUControl,
               Run, Illegal
    );
endinterface

// File: rtl/alu_seq_control.sv
// ---------------------------------------------------------------------------
// alu_seq_control
//
// Purpose: hardwired control sequencer for the phase-1 single-bus datapath.
// Runs fetch (T0-T2) and execute (T3-T6) of three-register ALU instructions
// straight from the IR contents and is the datapath's only control source.
//
// Ports:
//   Clock     in   rising-edge clock
//   Reset_n   in   asynchronous active-low reset
//   bus       alu_seq_control_if.master: IR/MemReady/Stop in, all strobes,
//             Rin/Rout selects, ALUControl, Run and Illegal out
//
// Parameters:
//   NREGS     number of general registers (width of Rin/Rout)
//
// Configuration macro:
//   ALU_SEQ_MULDIV_EN  when defined, MUL (15) and DIV (16) are decoded and
//                      the T6 step with LOin/HIin/ZHIout exists; otherwise
//                      those opcodes are illegal and the three strobes are 0.
// ---------------------------------------------------------------------------
module alu_seq_control #(
    parameter int NREGS = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    alu_seq_control_if.master bus
);

    localparam logic [2:0] S_T0   = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_T4   = 3'd4;
    localparam logic [2:0] S_T5   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [2:0] S_T6   = 3'd7;
`endif

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
`endif
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    logic [2:0] r_state;
    logic [2:0] w_nextState;
    logic [2:0] w_doneState;
    logic [4:0] w_opcode;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rc;
    logic [4:0] w_aluCode;
    logic       w_isAlu;
`ifdef ALU_SEQ_MULDIV_EN
    logic       w_isMulDiv;
`endif
    logic       w_unusedIrBits;

    assign w_opcode = bus.IR[31:27];
    assign w_ra     = bus.IR[26:23];
    assign w_rb     = bus.IR[22:19];
    assign w_rc     = bus.IR[18:15];

    // The low IR bits carry no meaning for three-register ALU instructions.
    assign w_unusedIrBits = &{1'b0, bus.IR[14:0]};

    // An index beyond the register file shifts the 1 above the kept bits,
    // so the select comes out all-zero instead of aliasing a real register.
    function automatic logic [NREGS-1:0] oneHot(input logic [3:0] idx);
        logic [NREGS+15:0] w_wide;
        w_wide = {{(NREGS + 15){1'b0}}, 1'b1} << idx;
        return w_wide[NREGS-1:0];
    endfunction

    // Opcode to ALU op select; a zero code marks "not an ALU instruction".
    always_comb begin
        w_aluCode = 5'b00000;
`ifdef ALU_SEQ_MULDIV_EN
        w_isMulDiv = 1'b0;
`endif
        case (w_opcode)
            OP_AND: w_aluCode = 5'b00001;
            OP_ADD: w_aluCode = 5'b00010;
            OP_SUB: w_aluCode = 5'b00011;
            OP_OR:  w_aluCode = 5'b00100;
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL: begin
                w_aluCode  = 5'b01000;
                w_isMulDiv = 1'b1;
            end
            OP_DIV: begin
                w_aluCode  = 5'b01001;
                w_isMulDiv = 1'b1;
            end
`endif
            default: w_aluCode = 5'b00000;
        endcase
    end

    assign w_isAlu = (w_aluCode != 5'b00000);

    // Where an instruction goes once it is complete: Stop is only honoured
    // at these boundaries.
    assign w_doneState = bus.Stop ? S_HALT : S_T0;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_T0: w_nextState = S_T1;
            S_T1: w_nextState = bus.MemReady ? S_T2 : S_T1;
            S_T2: w_nextState = S_T3;
            S_T3: begin
                if (w_isAlu)
                    w_nextState = S_T4;
                else if (w_opcode == OP_HALT)
                    w_nextState = S_HALT;
                else
                    w_nextState = w_doneState;
            end
            S_T4: w_nextState = S_T5;
`ifdef ALU_SEQ_MULDIV_EN
            S_T5: w_nextState = w_isMulDiv ? S_T6 : w_doneState;
            S_T6: w_nextState = w_doneState;
`else
            S_T5: w_nextState = w_doneState;
`endif
            S_HALT: w_nextState = S_HALT;
            default: w_nextState = S_T0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            r_state <= S_T0;
        else
            r_state <= w_nextState;
    end

    // Moore strobe decode. Everything is gated by Reset_n so that asserting
    // reset clears the strobes immediately, without waiting for an edge.
    always_comb begin
        bus.PCout       = 1'b0;
        bus.PCin        = 1'b0;
        bus.IncrementPC = 1'b0;
        bus.MARin       = 1'b0;
        bus.Read        = 1'b0;
        bus.MDRin       = 1'b0;
        bus.MDRout      = 1'b0;
        bus.IRin        = 1'b0;
        bus.Yin         = 1'b0;
        bus.Zin         = 1'b0;
        bus.ZLOout      = 1'b0;
        bus.ZHIout      = 1'b0;
        bus.HIin        = 1'b0;
        bus.LOin        = 1'b0;
        bus.Rin         = '0;
        bus.Rout        = '0;
        bus.ALUControl  = 5'b00000;
        bus.Run         = 1'b0;
        bus.Illegal     = 1'b0;
        if (Reset_n) begin
            bus.Run = (r_state != S_HALT);
            case (r_state)
                S_T0: begin
                    bus.PCout       = 1'b1;
                    bus.MARin       = 1'b1;
                    bus.IncrementPC = 1'b1;
                    bus.Zin         = 1'b1;
                end
                S_T1: begin
                    bus.ZLOout = 1'b1;
                    bus.PCin   = 1'b1;
                    bus.Read   = 1'b1;
                    bus.MDRin  = 1'b1;
                end
                S_T2: begin
                    bus.MDRout = 1'b1;
                    bus.IRin   = 1'b1;
                end
                S_T3: begin
                    if (w_isAlu) begin
                        bus.Rout = oneHot(w_rb);
                        bus.Yin  = 1'b1;
                    end else if (w_opcode != OP_NOP && w_opcode != OP_HALT) begin
                        bus.Illegal = 1'b1;
                    end
                end
                S_T4: begin
                    bus.Rout       = oneHot(w_rc);
                    bus.Zin        = 1'b1;
                    bus.ALUControl = w_aluCode;
                end
                S_T5: begin
                    bus.ZLOout = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
                    if (w_isMulDiv)
                        bus.LOin = 1'b1;
                    else
                        bus.Rin = oneHot(w_ra);
`else
                    bus.Rin = oneHot(w_ra);
`endif
                end
`ifdef ALU_SEQ_MULDIV_EN
                S_T6: begin
                    bus.ZHIout = 1'b1;
                    bus.HIin   = 1'b1;
                end
`endif
                default: begin
                    bus.Run = (r_state != S_HALT);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_control.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_control
//
// Purpose: self-checking bench for alu_seq_control. Each instruction's
// expected per-cycle strobe picture is pushed into a queue when it is issued;
// a monitor on the falling edge pops and compares one picture per cycle.
// Honours ALU_SEQ_MULDIV_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_alu_seq_control;

    localparam int NREGS = 12;
    localparam int NEVER = 1000;

    typedef struct packed {
        logic             pcOut;
        logic             pcIn;
        logic             incPc;
        logic             marIn;
        logic             read;
        logic             mdrIn;
        logic             mdrOut;
        logic             irIn;
        logic             yIn;
        logic             zIn;
        logic             zloOut;
        logic             zhiOut;
        logic             hiIn;
        logic             loIn;
        logic [NREGS-1:0] rin;
        logic [NREGS-1:0] rout;
        logic [4:0]       aluCtl;
        logic             run;
        logic             illegal;
    } snap_t;

    logic Clock;
    logic Reset_n;

    alu_seq_control_if #(.NREGS(NREGS)) bus ();

    alu_seq_control #(.NREGS(NREGS)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    snap_t expQ[$];
    int    checks;
    int    errors;
    int    cycleNo;
    bit    monitorOn;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference rules: which opcodes execute, their ALU code, register selects.
    function automatic bit modelIsMulDiv(input logic [4:0] op);
`ifdef ALU_SEQ_MULDIV_EN
        return (op == 5'd15) || (op == 5'd16);
`else
        return (op == 5'd31) && (op == 5'd30);
`endif
    endfunction

    function automatic logic [4:0] modelAluCode(input logic [4:0] op);
        if (op == 5'd5) return 5'b00001;
        if (op == 5'd3) return 5'b00010;
        if (op == 5'd4) return 5'b00011;
        if (op == 5'd6) return 5'b00100;
        if (modelIsMulDiv(op) && op == 5'd15) return 5'b01000;
        if (modelIsMulDiv(op) && op == 5'd16) return 5'b01001;
        return 5'b00000;
    endfunction

    function automatic bit modelIsAlu(input logic [4:0] op);
        return (op == 5'd3) || (op == 5'd4) || (op == 5'd5) || (op == 5'd6) ||
               modelIsMulDiv(op);
    endfunction

    function automatic logic [NREGS-1:0] sel(input logic [3:0] idx);
        logic [NREGS-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        if (int'(idx) < NREGS) return one << idx;
        return '0;
    endfunction

    function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc,
                                         input logic [14:0] low);
        return {op, ra, rb, rc, low};
    endfunction

    function automatic logic randBit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic snap_t sampleOutputs();
        snap_t s;
        s.pcOut   = bus.PCout;
        s.pcIn    = bus.PCin;
        s.incPc   = bus.IncrementPC;
        s.marIn   = bus.MARin;
        s.read    = bus.Read;
        s.mdrIn   = bus.MDRin;
        s.mdrOut  = bus.MDRout;
        s.irIn    = bus.IRin;
        s.yIn     = bus.Yin;
        s.zIn     = bus.Zin;
        s.zloOut  = bus.ZLOout;
        s.zhiOut  = bus.ZHIout;
        s.hiIn    = bus.HIin;
        s.loIn    = bus.LOin;
        s.rin     = bus.Rin;
        s.rout    = bus.Rout;
        s.aluCtl  = bus.ALUControl;
        s.run     = bus.Run;
        s.illegal = bus.Illegal;
        return s;
    endfunction

    task automatic checkOutput(input string name, input snap_t got, input snap_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: one expected picture per cycle, compared mid-cycle.
    always @(negedge Clock) begin
        if (monitorOn && expQ.size() > 0) begin
            checkOutput($sformatf("cycle%0d", cycleNo), sampleOutputs(), expQ.pop_front());
            cycleNo++;
        end
    end

    task automatic doReset();
        monitorOn = 1'b0;
        Reset_n   = 1'b0;
        #1;
        checkOutput("resetState", sampleOutputs(), '0);
        repeat (2) @(posedge Clock);
        #1;
        Reset_n   = 1'b1;
        monitorOn = 1'b1;
    endtask

    // Issues one instruction. waits = MemReady-low cycles in T1; Stop is held
    // high from cycle stopFrom on; abortAt >= 0 pulls reset mid-cycle there.
    task automatic applyStimulus(input logic [31:0] ir, input int waits, input int stopFrom,
                                 input int abortAt, input int idleAfter, output bit halted);
        snap_t      seq[$];
        snap_t      s;
        logic [4:0] op;
        int         last;
        int         total;
        op = ir[31:27];

        s = '0; s.run = 1; s.pcOut = 1; s.marIn = 1; s.incPc = 1; s.zIn = 1;
        seq.push_back(s);
        for (int i = 0; i <= waits; i++) begin
            s = '0; s.run = 1; s.zloOut = 1; s.pcIn = 1; s.read = 1; s.mdrIn = 1;
            seq.push_back(s);
        end
        s = '0; s.run = 1; s.mdrOut = 1; s.irIn = 1;
        seq.push_back(s);
        s = '0; s.run = 1;
        if (modelIsAlu(op)) begin
            s.rout = sel(ir[22:19]);
            s.yIn  = 1;
        end else if (op != 5'd26 && op != 5'd27) begin
            s.illegal = 1;
        end
        seq.push_back(s);
        if (modelIsAlu(op)) begin
            s = '0; s.run = 1; s.rout = sel(ir[18:15]); s.zIn = 1; s.aluCtl = modelAluCode(op);
            seq.push_back(s);
            s = '0; s.run = 1; s.zloOut = 1;
            if (modelIsMulDiv(op)) s.loIn = 1;
            else s.rin = sel(ir[26:23]);
            seq.push_back(s);
            if (modelIsMulDiv(op)) begin
                s = '0; s.run = 1; s.zhiOut = 1; s.hiIn = 1;
                seq.push_back(s);
            end
        end
        last   = seq.size() - 1;
        halted = (op == 5'd27) || (stopFrom <= last);
        if (abortAt >= 0) begin
            while (seq.size() > abortAt + 1) seq.delete(seq.size() - 1);
            halted = 1'b0;
        end else if (halted) begin
            for (int i = 0; i < idleAfter; i++) seq.push_back('0);
        end
        total = seq.size();
        foreach (seq[i]) expQ.push_back(seq[i]);

        bus.IR = ir;
        for (int k = 0; k < total; k++) begin
            if (k >= 1 && k <= waits) bus.MemReady = 1'b0;
            else if (k == waits + 1)  bus.MemReady = 1'b1;
            else                      bus.MemReady = randBit();
            if (k <= last)
                bus.Stop = (k >= stopFrom) ? 1'b1 : ((k == last) ? 1'b0 : randBit());
            else
                bus.Stop = randBit();
            if (k == abortAt) begin
                @(negedge Clock);
                #1;
                Reset_n = 1'b0;
                #1;
                checkOutput("asyncReset", sampleOutputs(), '0);
                monitorOn = 1'b0;
                @(posedge Clock);
                #1;
                Reset_n   = 1'b1;
                monitorOn = 1'b1;
            end else begin
                @(posedge Clock);
                #1;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit h;
        checks       = 0;
        errors       = 0;
        cycleNo      = 0;
        monitorOn    = 1'b0;
        Reset_n      = 1'b0;
        bus.IR       = '0;
        bus.MemReady = 1'b1;
        bus.Stop     = 1'b0;

        doReset();
        $display("[TB] directed instructions");
        applyStimulus(32'h28918000, 0, NEVER, -1, 0, h);
        applyStimulus(mkIr(5'd3, 4'd4, 4'd5, 4'd6, 15'h1234), 3, NEVER, -1, 0, h);
        applyStimulus(mkIr(5'd15, 4'd7, 4'd8, 4'd9, 15'h0), 0, NEVER, -1, 0, h);
        applyStimulus(mkIr(5'd16, 4'd1, 4'd2, 4'd0, 15'h7fff), 1, NEVER, -1, 0, h);
        applyStimulus(mkIr(5'd31, 4'd1, 4'd2, 4'd3, 15'h0), 0, NEVER, -1, 0, h);
        applyStimulus(mkIr(5'd26, 4'd3, 4'd3, 4'd3, 15'h0), 0, NEVER, -1, 0, h);
        applyStimulus(mkIr(5'd6, 4'd13, 4'd11, 4'd14, 15'h0), 0, NEVER, -1, 0, h);
        applyStimulus(mkIr(5'd4, 4'd0, 4'd15, 4'd12, 15'h0), 2, NEVER, -1, 0, h);

        $display("[TB] Stop during T4 of ADD");
        applyStimulus(mkIr(5'd3, 4'd2, 4'd3, 4'd4, 15'h0), 0, 4, -1, 3, h);
        doReset();

        $display("[TB] HALT opcode");
        applyStimulus(mkIr(5'd27, 4'd0, 4'd0, 4'd0, 15'h0), 1, NEVER, -1, 20, h);
        doReset();

        $display("[TB] reset mid-T4");
        applyStimulus(mkIr(5'd4, 4'd5, 4'd6, 4'd7, 15'h0), 0, NEVER, 4, 0, h);
        applyStimulus(mkIr(5'd5, 4'd9, 4'd10, 4'd11, 15'h0), 0, NEVER, -1, 0, h);

        $display("[TB] randomized instructions");
        for (int n = 0; n < 40; n++) begin
            logic [4:0] op;
            int         pick;
            int         stopAt;
            pick = int'($urandom_range(0, 9));
            case (pick)
                0: op = 5'd3;
                1: op = 5'd4;
                2: op = 5'd5;
                3: op = 5'd6;
                4: op = 5'd15;
                5: op = 5'd16;
                6: op = 5'd26;
                default: op = 5'($urandom_range(0, 31));
            endcase
            stopAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : NEVER;
            applyStimulus(mkIr(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                               4'($urandom_range(0, 15)), 15'($urandom)),
                          int'($urandom_range(0, 3)), stopAt, -1, 3, h);
            if (h) doReset();
        end

        @(negedge Clock);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL queueDrain: got %0d entries left expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
